// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the result path.
package fpu_pkg;

  // Bit positions inside the 5-bit IEEE exception vector.
  localparam int unsigned FLG_OVF  = 4;
  localparam int unsigned FLG_UNF  = 3;
  localparam int unsigned FLG_INX  = 2;
  localparam int unsigned FLG_DIVZ = 1;
  localparam int unsigned FLG_INV  = 0;

  // Widest request tag any FPU client is expected to carry.
  localparam int unsigned TAG_W_MAX = 16;

  // One rounded FPU result; the tag field is sized for the widest client.
  typedef struct packed {
    logic [63:0]          fp;
    logic [4:0]           flags;
    logic                 db;
    logic [TAG_W_MAX-1:0] tag;
  } fpu_result_t;

  // Width of a result excluding its tag (fp + flags + db).
  localparam int unsigned CORE_W = $bits(fpu_result_t) - TAG_W_MAX;

endpackage

// File: rtl/fpu_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with zeroed storage on reset.
module fpu_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage, pointer and occupancy update; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_result_buffer.sv
// Registered FPU result stage: FIFO buffering, sticky IEEE flags and trap pulse.
module fpu_result_buffer
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_fp,
  input  logic [4:0]                 in_flags,
  input  logic                       in_db,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_fp,
  output logic [4:0]                 out_flags,
  output logic                       out_db,
  output logic [TAG_W-1:0]           out_tag,
  input  logic                       flag_clr,
  input  logic [4:0]                 trap_en,
  output logic [4:0]                 sticky_flags,
  output logic                       trap,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned WIDTH = CORE_W + TAG_W;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;

  // in_ready depends only on occupancy, never on out_ready.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;

  // Entry layout matches fpu_result_t with the tag trimmed to TAG_W.
  assign wr_data = {in_fp, in_flags, in_db, in_tag};
  assign {out_fp, out_flags, out_db, out_tag} = rd_data;

  fpu_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Sticky flags accumulate at push time; clear takes effect before accumulation.
  // Trap pulses the cycle after a push raising any enabled exception.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_flags <= '0;
      trap         <= 1'b0;
    end else begin
      sticky_flags <= (flag_clr ? 5'b0 : sticky_flags) | (push ? in_flags : 5'b0);
      trap         <= push && ((in_flags & trap_en) != 5'b0);
    end
  end

endmodule

// File: doc/fpu_result_buffer.md
Name: fpu_result_buffer

Overview:
- Registered output stage directly downstream of the combinational FPU top (unpack -> add -> round).
- Captures each rounded result (64-bit fp word, 5-bit IEEE exception vector, precision bit, tag) into a small synchronous FIFO.
- Presents results to the consumer with valid/ready, accumulates IEEE sticky exception flags, and raises a trap pulse for enabled exceptions.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the opaque request tag carried with each result.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  producer has a result this cycle.
- in_ready  output  1  buffer can accept; equals !full, no combinational path from out_ready.
- in_fp  input  64  rounded result from the rounder.
- in_flags  input  5  IEEE vector: [4]=OVF, [3]=UNF, [2]=INX, [1]=DIVZ, [0]=INV.
- in_db  input  1  1 = double, 0 = single.
- in_tag  input  TAG_W  request tag.
- out_valid  output  1  head entry valid (!empty).
- out_ready  input  1  consumer accepts head.
- out_fp  output  64  head fp word.
- out_flags  output  5  head exception vector.
- out_db  output  1  head precision bit.
- out_tag  output  TAG_W  head tag.
- flag_clr  input  1  clear sticky flags.
- trap_en  input  5  per-flag trap enable, same bit order as in_flags.
- sticky_flags  output  5  accumulated exception flags.
- trap  output  1  one-cycle pulse.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Reset (rst_n low at a clk edge): wr_ptr, rd_ptr, count, sticky_flags and trap all go to 0; out_valid = 0. All storage entries are zeroed, so out_fp, out_flags, out_db and out_tag read 0 after reset. Reset overrides any push, pop or flag_clr in the same cycle.
- Latency: an entry pushed at edge N is visible on the out_* ports and out_valid after edge N; one cycle in to out. No combinational bypass from in_* to out_*.
- out_* are driven from storage[rd_ptr], a registered array read. Their values are don't-care while out_valid = 0 after the first pop; bench checks them only when out_valid = 1.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full (count == DEPTH):
  - in_ready = 0; in_valid is ignored and nothing is written.
  - A pop in the same cycle does not enable a push; in_ready rises the next cycle.
- Empty (count == 0):
  - out_valid = 0; out_ready is ignored.
  - A push into an empty buffer is not forwarded the same cycle.
- Sticky flags, next value:
  - flag_clr=0, push=0: hold.
  - flag_clr=0, push=1: sticky | in_flags.
  - flag_clr=1, push=0: 0.
  - flag_clr=1, push=1: in_flags (clear first, then accumulate).
  - Accumulation happens at push time, not at pop.
- Trap: registered; trap = 1 for exactly the cycle after a push with (in_flags & trap_en) != 0, else 0. Back-to-back qualifying pushes give trap high on consecutive cycles. trap_en is sampled in the push cycle.
- The block does not inspect or modify fp/db contents; they pass through bit-exact.

Decomposition:
- Shared package fpu_pkg:
  - Flag bit index constants FLG_OVF=4, FLG_UNF=3, FLG_INX=2, FLG_DIVZ=1, FLG_INV=0.
  - Packed struct fpu_result_t {fp[63:0], flags[4:0], db, tag}. Tag is width-parameterised via TAG_W at the use site; the struct holds a max-width tag or the FIFO is parameterised on width.
- One natural sub-module: fpu_sync_fifo, a generic DEPTH x WIDTH synchronous FIFO with push/pop/full/empty/count and synchronous active-low reset.
- fpu_result_buffer instantiates fpu_sync_fifo and adds the sticky-flag and trap logic.

Test Plan:
1. Reset, then push in_fp=64'h3FF0000000000000, in_flags=5'b00100, in_tag=3, one cycle -> next cycle out_valid=1, out_fp=3FF0...0, out_flags=00100, out_tag=3; sticky_flags=00100; count=1.
2. Push 4 entries with out_ready=0 -> count=4, in_ready=0. Hold in_valid=1 with a 5th value -> not stored. Then pop 4 -> tags emerge 0,1,2,3 in order, across a pointer wrap.
3. With count=2, assert push and pop in the same cycle for 6 cycles -> count stays 2, order preserved, no loss or duplication.
4. Push flags 00001, then 10000 -> sticky=10001. Next cycle flag_clr=1 with push flags 00100 -> sticky=00100. Then flag_clr alone -> sticky=00000.
5. trap_en=5'b10000; push flags 00100 -> trap stays 0. Push flags 10100 -> trap=1 exactly one cycle later, then 0.
6. At full with pending pushes, assert rst_n=0 for one edge -> count=0, out_valid=0, sticky=0, trap=0, out_fp=0, in_ready=1 the following cycle.
